// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe: pipelined signed fixed-point multiplier, Q(WIDTH-FRAC).FRAC in and out.
// Structure: one operand register rank, then LAT result ranks. The multiply, round and
// saturate logic sits between the operand rank and the first result rank, so an operation
// accepted at edge N shows up on out_valid after edge N+LAT.
// The whole pipe stalls together while the output holds an unaccepted result.
// Optional feature macro: FXP_MULT_ROUND_EN (round half toward +inf instead of truncating).
module fxp_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LAT   = 2,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag,
  input  logic             sat_clr,
  output logic [15:0]      sat_count
);

  localparam int PW = 2 * WIDTH;

  // Operand rank
  logic             r_op_vld;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [TAG_W-1:0] r_op_tag;

  // Result ranks; index LAT drives the outputs
  logic             r_vld  [1:LAT];
  logic [WIDTH-1:0] r_data [1:LAT];
  logic             r_sat  [1:LAT];
  logic [TAG_W-1:0] r_tag  [1:LAT];

  logic [15:0]      r_sat_count;

  logic                 w_stall;
  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_rsum;
  logic signed [PW-1:0] w_shift;
  logic [WIDTH:0]       w_head;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_res;
  logic                 w_res_sat;

  // Stall only depends on the output handshake, never on in_valid
  assign w_stall  = r_vld[LAT] & ~out_ready;
  assign in_ready = ~w_stall;

  // Sign-extend both operands to the full product width so the product is exact
  assign w_a_ext = {{WIDTH{r_op_a[WIDTH-1]}}, r_op_a};
  assign w_b_ext = {{WIDTH{r_op_b[WIDTH-1]}}, r_op_b};
  assign w_prod  = w_a_ext * w_b_ext;

`ifdef FXP_MULT_ROUND_EN
  // Half an LSB of the result format, added before the shift
  localparam logic signed [PW-1:0] RND_C = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
  assign w_rsum = w_prod + RND_C;
`else
  assign w_rsum = w_prod;
`endif

  assign w_shift = w_rsum >>> FRAC;

  // The value fits in WIDTH bits when all bits from the result sign upward agree
  assign w_head = w_shift[PW-1:WIDTH-1];
  assign w_fits = (&w_head) | ~(|w_head);

  // Clip to the nearest range limit when the shifted product does not fit
  always_comb begin
    w_res     = w_shift[WIDTH-1:0];
    w_res_sat = 1'b0;
    if (!w_fits) begin
      w_res_sat = 1'b1;
      if (w_shift[PW-1]) begin
        w_res = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_res = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      w_res     = w_shift[WIDTH-1:0];
      w_res_sat = 1'b0;
    end
  end

  // Pipeline advance: every rank moves together unless the output is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_vld <= 1'b0;
      r_op_a   <= {WIDTH{1'b0}};
      r_op_b   <= {WIDTH{1'b0}};
      r_op_tag <= {TAG_W{1'b0}};
      for (int i = 1; i <= LAT; i++) begin
        r_vld[i]  <= 1'b0;
        r_data[i] <= {WIDTH{1'b0}};
        r_sat[i]  <= 1'b0;
        r_tag[i]  <= {TAG_W{1'b0}};
      end
    end else if (!w_stall) begin
      r_op_vld  <= in_valid;
      r_op_a    <= in_a;
      r_op_b    <= in_b;
      r_op_tag  <= in_tag;
      r_vld[1]  <= r_op_vld;
      r_data[1] <= w_res;
      r_sat[1]  <= w_res_sat;
      r_tag[1]  <= r_op_tag;
      for (int i = 2; i <= LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
        r_sat[i]  <= r_sat[i-1];
        r_tag[i]  <= r_tag[i-1];
      end
    end
  end

  // Saturation event counter: clear wins, holds at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_count <= 16'h0000;
    end else if (sat_clr) begin
      r_sat_count <= 16'h0000;
    end else if (r_vld[LAT] && out_ready && r_sat[LAT] && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign out_valid = r_vld[LAT];
  assign out_data  = r_data[LAT];
  assign out_sat   = r_sat[LAT];
  assign out_tag   = r_tag[LAT];
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed bench for fxp_mult_pipe: LAT=2 main instance plus LAT=1 / LAT=4 sweep instances.
// Expected values follow FXP_MULT_ROUND_EN when it is defined for the build.
module tb_fxp_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_sat, sat_clr;
  logic [15:0] in_a, in_b, out_data, sat_count;
  logic [7:0]  in_tag, out_tag;

  logic        v_valid;
  logic [15:0] v_a, v_b;
  logic [7:0]  v_tag;
  logic        l1_ready, l1_valid, l1_sat, l4_ready, l4_valid, l4_sat;
  logic [15:0] l1_data, l1_cnt, l4_data, l4_cnt;
  logic [7:0]  l1_tag, l4_tag;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FXP_MULT_ROUND_EN
  localparam logic [15:0] EXP_RP = 16'h0001;
  localparam logic [15:0] EXP_RN = 16'h0000;
`else
  localparam logic [15:0] EXP_RP = 16'h0000;
  localparam logic [15:0] EXP_RN = 16'hFFFF;
`endif

  fxp_mult_pipe #(.WIDTH(16), .FRAC(8), .LAT(2), .TAG_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .out_tag(out_tag), .sat_clr(sat_clr), .sat_count(sat_count));

  fxp_mult_pipe #(.WIDTH(16), .FRAC(8), .LAT(1), .TAG_W(8)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_valid), .in_ready(l1_ready),
    .in_a(v_a), .in_b(v_b), .in_tag(v_tag), .out_valid(l1_valid),
    .out_ready(1'b1), .out_data(l1_data), .out_sat(l1_sat),
    .out_tag(l1_tag), .sat_clr(1'b0), .sat_count(l1_cnt));

  fxp_mult_pipe #(.WIDTH(16), .FRAC(8), .LAT(4), .TAG_W(8)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_valid), .in_ready(l4_ready),
    .in_a(v_a), .in_b(v_b), .in_tag(v_tag), .out_valid(l4_valid),
    .out_ready(1'b1), .out_data(l4_data), .out_sat(l4_sat),
    .out_tag(l4_tag), .sat_clr(1'b0), .sat_count(l4_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product, optional half-LSB, floor shift, clip
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint s;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef FXP_MULT_ROUND_EN
    p = p + 128;
`endif
    s = p >>> 8;
    if (s > 32767) return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else return {1'b0, s[15:0]};
  endfunction

  // One operation through the LAT=2 instance with out_ready high
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag,
                         input logic [15:0] exp_d, input logic exp_s, input string nm);
    int cnt;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick;
      cnt++;
    end
    chk({nm, "_lat"}, 32'(cnt), 32'd2);
    chk({nm, "_data"}, 32'(out_data), 32'(exp_d));
    chk({nm, "_sat"}, 32'(out_sat), 32'(exp_s));
    chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; in_tag = 8'h00;
    out_ready = 1'b1; sat_clr = 1'b0;
    v_valid = 1'b0; v_a = 16'h0000; v_b = 16'h0000; v_tag = 8'h00;
    tick; tick;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic products
    run_one(16'h0180, 16'h0200, 8'h5A, 16'h0300, 1'b0, "mul_pos");
    run_one(16'hFF00, 16'h0100, 8'h11, 16'hFF00, 1'b0, "mul_neg");

    // Saturation and counter
    run_one(16'h6400, 16'h0200, 8'h21, 16'h7FFF, 1'b1, "sat_hi");
    run_one(16'h8000, 16'h7FFF, 8'h22, 16'h8000, 1'b1, "sat_lo");
    tick;
    chk("sat_count_2", 32'(sat_count), 32'd2);
    run_one(16'h6400, 16'h0200, 8'h23, 16'h7FFF, 1'b1, "sat_hi2");
    sat_clr = 1'b1;
    tick;
    sat_clr = 1'b0;
    chk("sat_clr_wins", 32'(sat_count), 32'd0);
    tick;
    chk("sat_clr_hold", 32'(sat_count), 32'd0);

    // Rounding boundary
    run_one(16'h0001, 16'h0080, 8'h31, EXP_RP, 1'b0, "rnd_pos");
    run_one(16'hFFFF, 16'h0080, 8'h32, EXP_RN, 1'b0, "rnd_neg");
    tick;

    // Backpressure: tags 1..8 streamed, out_ready low for 3 cycles mid-stream
    begin
      int k, nexp, cyc, extra;
      logic acc, dlv;
      k = 1; nexp = 1; cyc = 0;
      while (nexp <= 8 && cyc < 60) begin
        out_ready = !(cyc >= 5 && cyc <= 7);
        in_valid  = (k <= 8);
        in_a      = 16'(k) << 8;
        in_b      = 16'h0100;
        in_tag    = 8'(k);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (out_valid) begin
          chk("bp_tag", 32'(out_tag), 32'(nexp));
          chk("bp_data", 32'(out_data), 32'(nexp << 8));
        end
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        tick;
        if (acc) k++;
        if (dlv) nexp++;
        cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_delivered", 32'(nexp), 32'd9);
      chk("bp_accepted", 32'(k), 32'd9);
      extra = 0;
      repeat (4) begin
        if (out_valid) extra++;
        tick;
      end
      chk("bp_no_dup", 32'(extra), 32'd0);
    end

    // Reset mid-operation
    run_one(16'h6400, 16'h0200, 8'h41, 16'h7FFF, 1'b1, "pre_rst");
    tick;
    chk("pre_rst_count", 32'(sat_count), 32'd1);
    begin
      int seen;
      in_a = 16'h6400; in_b = 16'h0200; in_tag = 8'h42; in_valid = 1'b1;
      tick; tick;
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_count", 32'(sat_count), 32'd0);
      seen = 0;
      repeat (6) begin
        if (out_valid) seen++;
        tick;
      end
      chk("mid_rst_no_stale", 32'(seen), 32'd0);
    end

    // LAT=1 / LAT=4 sweep against the reference model
    for (int t = 0; t < 12; t++) begin
      logic [15:0] a, b, d1, d4;
      logic [16:0] exp;
      logic        s1, s4;
      logic [7:0]  tg4;
      int          lat1, lat4;
      case (t)
        0: begin a = 16'h8000; b = 16'h8000; end
        1: begin a = 16'h8000; b = 16'h0100; end
        2: begin a = 16'h7FFF; b = 16'h8000; end
        3: begin a = 16'h8000; b = 16'hFF00; end
        default: begin a = 16'($urandom); b = 16'($urandom_range(0, 1023)) - 16'd512; end
      endcase
      exp = model(a, b);
      v_a = a; v_b = b; v_tag = 8'(t); v_valid = 1'b1;
      tick;
      v_valid = 1'b0;
      lat1 = -1; lat4 = -1;
      d1 = 16'h0000; d4 = 16'h0000; s1 = 1'b0; s4 = 1'b0; tg4 = 8'h00;
      for (int c = 1; c <= 8; c++) begin
        tick;
        if (l1_valid && lat1 < 0) begin lat1 = c; d1 = l1_data; s1 = l1_sat; end
        if (l4_valid && lat4 < 0) begin lat4 = c; d4 = l4_data; s4 = l4_sat; tg4 = l4_tag; end
      end
      chk("sweep_lat1", 32'(lat1), 32'd1);
      chk("sweep_lat4", 32'(lat4), 32'd4);
      chk("sweep_data1", 32'(d1), 32'(exp[15:0]));
      chk("sweep_data4", 32'(d4), 32'(exp[15:0]));
      chk("sweep_sat1", 32'(s1), 32'(exp[16]));
      chk("sweep_sat4", 32'(s4), 32'(exp[16]));
      chk("sweep_tag4", 32'(tg4), 32'(t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
